// File: rtl/blink_region_mux_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | blink_region_mux_if                                                   |
// | Pixel-path, sync and region-configuration bundle for blink_region_mux |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface blink_region_mux_if #(
  parameter int PIXEL_W     = 5,
  parameter int COORD_W     = 10,
  parameter int NUM_REGIONS = 2,
  parameter int PERIOD_W    = 6
);
  logic                           VS;
  logic [COORD_W-1:0]             DrawX;
  logic [COORD_W-1:0]             DrawY;
  logic [1:0]                     gameState;
  logic [PIXEL_W-1:0]             pixelIn;
  logic [NUM_REGIONS-1:0]         region_en;
  logic [NUM_REGIONS-1:0]         region_inv;
  logic [NUM_REGIONS*COORD_W-1:0] region_x0;
  logic [NUM_REGIONS*COORD_W-1:0] region_x1;
  logic [NUM_REGIONS*COORD_W-1:0] region_y0;
  logic [NUM_REGIONS*COORD_W-1:0] region_y1;
  logic [PERIOD_W-1:0]            on_frames;
  logic [PERIOD_W-1:0]            off_frames;
  logic [PIXEL_W-1:0]             pixelOut;
  logic                           frame_tick;
  logic                           blink_hidden;

  modport master (
    output VS, DrawX, DrawY, gameState, pixelIn,
    output region_en, region_inv, region_x0, region_x1, region_y0, region_y1,
    output on_frames, off_frames,
    input  pixelOut, frame_tick, blink_hidden
  );

  modport slave (
    input  VS, DrawX, DrawY, gameState, pixelIn,
    input  region_en, region_inv, region_x0, region_x1, region_y0, region_y1,
    input  on_frames, off_frames,
    output pixelOut, frame_tick, blink_hidden
  );
endinterface
`default_nettype wire

// File: rtl/blink_region_mux.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | blink_region_mux                                                      |
// | Frame-counted blink overlay replacing the palette index inside up to  |
// | NUM_REGIONS rectangles. Define BLINK_PIPE_EN to register pixelOut.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module blink_region_mux #(
  parameter int                 PIXEL_W      = 5,
  parameter int                 COORD_W      = 10,
  parameter int                 NUM_REGIONS  = 2,
  parameter int                 PERIOD_W     = 6,
  parameter logic [PIXEL_W-1:0] FILL_INDEX   = '0,
  parameter logic [1:0]         ACTIVE_STATE = 2'b00
) (
  input  logic                frame_Clk,
  input  logic                Reset,
  blink_region_mux_if.slave   bus
);

  typedef enum logic [1:0] {
    S_FRONT = 2'd0,
    S_SYNC  = 2'd1,
    S_BACK  = 2'd2
  } sync_state_t;

  typedef enum logic [0:0] {
    B_SHOW = 1'b0,
    B_HIDE = 1'b1
  } blink_state_t;

  localparam logic [PERIOD_W:0] c_CNT_ONE = {{PERIOD_W{1'b0}}, 1'b1};

  sync_state_t            r_sync_state;
  sync_state_t            w_sync_next;
  blink_state_t           r_blink_state;
  blink_state_t           w_blink_next;
  logic [PERIOD_W-1:0]    r_cnt;
  logic [PERIOD_W-1:0]    w_cnt_next;
  logic [PERIOD_W:0]      w_cnt_inc;
  logic [PERIOD_W:0]      w_limit;
  logic                   w_frame_tick;
  logic                   w_active;
  logic                   w_hold;
  logic                   w_hidden_phase;
  logic [NUM_REGIONS-1:0] w_region_hidden;
  logic [PIXEL_W-1:0]     w_pixel;

  // Sync FSM: one SYNC cycle per VS low period, however long VS stays low
  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      r_sync_state <= S_FRONT;
    end else begin
      r_sync_state <= w_sync_next;
    end
  end

  always_comb begin
    w_sync_next = r_sync_state;
    case (r_sync_state)
      S_FRONT: if (!bus.VS) w_sync_next = S_SYNC;
      S_SYNC:  w_sync_next = S_BACK;
      S_BACK:  if (bus.VS) w_sync_next = S_FRONT;
      default: w_sync_next = S_FRONT;
    endcase
  end

  assign w_frame_tick = (r_sync_state == S_SYNC);

  assign w_active  = (bus.gameState == ACTIVE_STATE);
  assign w_hold    = !w_active || (bus.on_frames == '0) || (bus.off_frames == '0);
  // One extra bit so an all-ones limit is reachable without wrapping
  assign w_limit   = {1'b0, (r_blink_state == B_SHOW) ? bus.on_frames : bus.off_frames};
  assign w_cnt_inc = {1'b0, r_cnt} + c_CNT_ONE;

  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      r_blink_state <= B_SHOW;
      r_cnt         <= '0;
    end else begin
      r_blink_state <= w_blink_next;
      r_cnt         <= w_cnt_next;
    end
  end

  always_comb begin
    w_blink_next = r_blink_state;
    w_cnt_next   = r_cnt;
    if (w_hold) begin
      w_blink_next = B_SHOW;
      w_cnt_next   = '0;
    end else if (w_frame_tick) begin
      if (w_cnt_inc >= w_limit) begin
        w_blink_next = (r_blink_state == B_SHOW) ? B_HIDE : B_SHOW;
        w_cnt_next   = '0;
      end else begin
        w_cnt_next   = w_cnt_inc[PERIOD_W-1:0];
      end
    end
  end

  assign w_hidden_phase = (r_blink_state == B_HIDE);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
      logic [COORD_W-1:0] w_x0;
      logic [COORD_W-1:0] w_x1;
      logic [COORD_W-1:0] w_y0;
      logic [COORD_W-1:0] w_y1;
      logic               w_hit;

      assign w_x0  = bus.region_x0[gi*COORD_W +: COORD_W];
      assign w_x1  = bus.region_x1[gi*COORD_W +: COORD_W];
      assign w_y0  = bus.region_y0[gi*COORD_W +: COORD_W];
      assign w_y1  = bus.region_y1[gi*COORD_W +: COORD_W];
      // Exclusive bounds: degenerate rectangles can never hit
      assign w_hit = bus.region_en[gi]
                   && (w_x0 < bus.DrawX) && (bus.DrawX < w_x1)
                   && (w_y0 < bus.DrawY) && (bus.DrawY < w_y1);
      assign w_region_hidden[gi] = w_hit && (w_hidden_phase ^ bus.region_inv[gi]) && w_active;
    end
  endgenerate

  assign w_pixel = (|w_region_hidden) ? FILL_INDEX : bus.pixelIn;

`ifdef BLINK_PIPE_EN
  logic [PIXEL_W-1:0] r_pixel_out;

  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      r_pixel_out <= '0;
    end else begin
      r_pixel_out <= w_pixel;
    end
  end

  assign bus.pixelOut = r_pixel_out;
`else
  assign bus.pixelOut = w_pixel;
`endif

  assign bus.frame_tick   = w_frame_tick;
  assign bus.blink_hidden = w_hidden_phase;

endmodule
`default_nettype wire
